fibonacci_display_sequencer: RTL

// Sequencer for the Fibonacci-to-number-display datapath. It holds the Fibonacci

---
 rtl/fibonacci_display_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fibonacci_display_sequencer.sv
// Fibonacci sequencer with step/auto-run advance, wrap on overflow and an
// iterative double-dabble converter so the display only sees finished BCD.
//
// state   | meaning
// IDLE    | holding value; waiting for step or period-timer expiry
// CONVERT | shifting value through double-dabble, one bit per cycle
module fibonacci_display_sequencer #(
    parameter int NUMBER_WIDTH = 16,
    parameter int STEP_PERIOD  = 64,
    localparam int DIGITS = $rtoi($ceil(NUMBER_WIDTH * $log10(2.0)))
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      run,
    input  logic                      step,
    input  logic                      restart,
    output logic [NUMBER_WIDTH-1:0]   value,
    output logic [4*DIGITS-1:0]       bcd,
    output logic                      bcd_valid,
    output logic                      busy,
    output logic                      overflow
);

    localparam int CNT_W  = (STEP_PERIOD > 2) ? $clog2(STEP_PERIOD) : 1;
    localparam int ITER_W = (NUMBER_WIDTH > 2) ? $clog2(NUMBER_WIDTH) : 1;
    localparam int BCD_W  = 4 * DIGITS;
    localparam int SH_W   = BCD_W + NUMBER_WIDTH;

    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(STEP_PERIOD - 1);
    localparam logic [ITER_W-1:0]     ITER_LAST = ITER_W'(NUMBER_WIDTH - 1);
    localparam logic [NUMBER_WIDTH:0] B_INIT    = (NUMBER_WIDTH + 1)'(1);

    typedef enum logic {
        IDLE,
        CONVERT
    } state_t;

    state_t                  state_q, state_d;
    logic [NUMBER_WIDTH-1:0] a_q, a_d;
    logic [NUMBER_WIDTH:0]   b_q, b_d;
    logic                    ovf_q, ovf_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ITER_W-1:0]       iter_q, iter_d;
    logic [SH_W-1:0]         sh_q, sh_d;
    logic [SH_W-1:0]         sh_adj;
    logic [BCD_W-1:0]        bcd_q, bcd_d;
    logic                    valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ovf_d   = ovf_q;
        cnt_d   = run ? cnt_q + 1'b1 : '0;
        iter_d  = iter_q;
        sh_d    = sh_q;
        bcd_d   = bcd_q;
        valid_d = valid_q;

        // Double-dabble correction: bias every nibble >= 5 before the shift.
        sh_adj = sh_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (sh_adj[NUMBER_WIDTH + 4*i +: 4] >= 4'd5) begin
                sh_adj[NUMBER_WIDTH + 4*i +: 4] = sh_adj[NUMBER_WIDTH + 4*i +: 4] + 4'd3;
            end
        end

        if (restart) begin
            a_d     = '0;
            b_d     = B_INIT;
            ovf_d   = 1'b0;
            cnt_d   = '0;
            iter_d  = '0;
            bcd_d   = '0;
            valid_d = 1'b1;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (step || (run && (cnt_q == CNT_LAST))) begin
                        if (b_q[NUMBER_WIDTH]) begin
                            a_d   = '0;
                            b_d   = B_INIT;
                            ovf_d = 1'b1;
                        end else begin
                            a_d = b_q[NUMBER_WIDTH-1:0];
                            b_d = {1'b0, a_q} + {1'b0, b_q[NUMBER_WIDTH-1:0]};
                        end
                        sh_d    = {{BCD_W{1'b0}}, a_d};
                        cnt_d   = '0;
                        iter_d  = '0;
                        valid_d = 1'b0;
                        state_d = CONVERT;
                    end
                end
                CONVERT: begin
                    sh_d   = sh_adj << 1;
                    iter_d = iter_q + 1'b1;
                    if (iter_q == ITER_LAST) begin
                        bcd_d   = sh_d[SH_W-1 -: BCD_W];
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= B_INIT;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            iter_q  <= '0;
            sh_q    <= '0;
            bcd_q   <= '0;
            valid_q <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            iter_q  <= iter_d;
            sh_q    <= sh_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
        end
    end

    assign value     = a_q;
    assign bcd       = bcd_q;
    assign bcd_valid = valid_q;
    assign busy      = (state_q == CONVERT);
    assign overflow  = ovf_q;

endmodule
